mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, address width of both requester ports and the memory port.
REQ-002 Parameter: DATA_W, 16, data width of write data, read data and the LED register.
REQ-003 Clock  input  1  all state updates on the negative edge, matching the processor datapath.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the active Clock edge.
REQ-005 req0 / req1  input  1  access request from requester 0 (processor) / requester 1 (loader).
REQ-006 we0 / we1  input  1  access is a write (1) or a read (0).
REQ-007 addr0 / addr1  input  ADDR_W  access address.
REQ-008 wdata0 / wdata1  input  DATA_W  write data.
REQ-009 gnt0 / gnt1  output  1  access issued this cycle; combinational from req and the registered state.
REQ-010 rvalid0 / rvalid1  output  1  read data valid on rdata for that requester.
REQ-011 rdata  output  DATA_W  shared read-data return.
REQ-012 lock0 / lock1  input  1  hold ownership across consecutive accesses; present only with MEM_ARB_LOCK_EN.
REQ-013 mem_addr  output  ADDR_W  RAM address, equal to the granted requester's addr, or 0 when idle.
REQ-014 mem_data  output  DATA_W  RAM write data, equal to the granted requester's wdata.
REQ-015 mem_wren  output  1  RAM write enable.
REQ-016 mem_q  input  DATA_W  RAM read data, valid one cycle after the address is issued.
REQ-017 led  output  DATA_W  memory-mapped LED register.

Function
REQ-018 Address decode: addr[15:12]==0 selects RAM; addr[15:12]==1 selects the LED register; all other values select an unmapped region.
REQ-019 A transaction is exactly one gnt cycle, and at most one of gnt0/gnt1 is high in any cycle.
REQ-020 A requester holds req, we, addr and wdata stable until it sees gnt; each req-high cycle under gnt counts as one access.
REQ-021 Round-robin: a registered pointer `last` names the most recent grantee. On contention, the other requester wins; a single requester wins immediately (zero wait).
REQ-022 `last` updates to the grantee on every grant cycle.
REQ-023 mem_wren = gnt & we & RAM-selected. A write to the LED region loads led with wdata at the edge; a write to an unmapped address is dropped.
REQ-024 Read latency: rvalidX is high exactly one cycle after a read gnt for requester X.
REQ-025 rdata for a read is mem_q (RAM), the led value at grant time (LED region), or 0 (unmapped).
REQ-026 Writes never assert rvalid.
REQ-027 Back-to-back grants are allowed in consecutive cycles, including alternating grants under sustained contention.

Reset
REQ-028 While Reset is high at an edge, the block clears: `last` to 1 (so requester 0 wins the first contention), led to 0, rvalid0/rvalid1 to 0, and the lock state to IDLE.
REQ-029 A read granted in the cycle Reset is applied produces no rvalid.
REQ-030 gnt remains combinational during reset; mem_wren is forced to 0 while Reset is high.

Configuration
REQ-031 With MEM_ARB_LOCK_EN defined: the ports lock0/lock1 exist, and a lock FSM with states IDLE, OWN0 and OWN1 is implemented. A grant to X with lockX high moves the FSM to OWNx. In OWNx only X can be granted, and other requests wait. The FSM returns to IDLE on the first cycle lockX is low.
REQ-032 Without MEM_ARB_LOCK_EN defined: the lock ports and FSM are absent, and arbitration is pure round-robin every cycle.

Verification
REQ-033 Reset, then req0 write 0x0005 <- 0x1234 -> gnt0 the same cycle and mem_wren=1 with mem_addr=0x0005. A subsequent read of 0x0005 gives rvalid0 one cycle later with rdata=0x1234.
REQ-034 req0 and req1 asserted together for 4 cycles immediately after reset -> grants 0,1,0,1, with no double grant.
REQ-035 req1 write 0x1000 <- 0x00A5 -> led=0x00A5 after the edge and mem_wren=0. A read of 0x1000 returns 0x00A5.
REQ-036 A read of 0x2000 -> rvalid with rdata=0x0000. A write to 0x3000 -> led and RAM unchanged.
REQ-037 With MEM_ARB_LOCK_EN defined: lock0 is held for 3 accesses while req1 is pending -> gnt0 x3 then gnt1, and gnt1 is never asserted during OWN0.
REQ-038 Reset asserted in a read gnt cycle -> no rvalid, led=0, and the next contention is granted to requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin access to one RAM port plus a memory-mapped LED register.
// Optional MEM_ARB_LOCK_EN adds lock0/lock1 ports and an ownership FSM (IDLE/OWN0/OWN1).
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic              i_lock0,
    input  logic              i_lock1,
`endif
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic [DATA_W-1:0] o_led
);

    localparam logic [3:0] REGION_RAM = 4'h0;
    localparam logic [3:0] REGION_LED = 4'h1;

    logic              r_last;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_rd_is_ram;
    logic [DATA_W-1:0] r_rd_reg;
    logic [DATA_W-1:0] r_led;

    logic              w_rr_gnt0;
    logic              w_rr_gnt1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_region;
    logic              w_ram_sel;
    logic              w_led_sel;
    logic              w_rd_gnt;

    // Round-robin: on contention the requester that did not win last time goes first.
    assign w_rr_gnt0 = i_req0 & (~i_req1 | r_last);
    assign w_rr_gnt1 = i_req1 & (~i_req0 | ~r_last);

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } lock_state_t;

    lock_state_t r_state;
    lock_state_t w_state_next;

    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // While a requester owns the port, the other one is held off.
    always_comb begin
        w_state_next = r_state;
        w_gnt0       = w_rr_gnt0;
        w_gnt1       = w_rr_gnt1;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_gnt0 && i_lock0) begin
                    w_state_next = ST_OWN0;
                end else if (w_rr_gnt1 && i_lock1) begin
                    w_state_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                w_gnt0 = i_req0;
                w_gnt1 = 1'b0;
                if (!i_lock0) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_OWN1: begin
                w_gnt0 = 1'b0;
                w_gnt1 = i_req1;
                if (!i_lock1) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end
`else
    assign w_gnt0 = w_rr_gnt0;
    assign w_gnt1 = w_rr_gnt1;
`endif

    // Mux the granted requester onto the shared access path.
    assign w_any_gnt = w_gnt0 | w_gnt1;
    assign w_we      = w_gnt1 ? i_we1    : i_we0;
    assign w_addr    = w_gnt1 ? i_addr1  : i_addr0;
    assign w_wdata   = w_gnt1 ? i_wdata1 : i_wdata0;
    assign w_region  = w_addr[15:12];
    assign w_ram_sel = (w_region == REGION_RAM);
    assign w_led_sel = (w_region == REGION_LED);
    assign w_rd_gnt  = w_any_gnt & ~w_we;

    assign o_gnt0     = w_gnt0;
    assign o_gnt1     = w_gnt1;
    assign o_mem_addr = w_any_gnt ? w_addr  : '0;
    assign o_mem_data = w_any_gnt ? w_wdata : '0;
    assign o_mem_wren = w_any_gnt & w_we & w_ram_sel & ~i_reset;

    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            r_last    <= 1'b1;
            r_led     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
            if (w_any_gnt && w_we && w_led_sel) begin
                r_led <= w_wdata;
            end
            r_rvalid0 <= w_gnt0 & ~i_we0;
            r_rvalid1 <= w_gnt1 & ~i_we1;
        end
    end

    // Read-return source: RAM data arrives next cycle; LED/unmapped values are captured at grant.
    always_ff @(negedge i_clock) begin
        if (w_rd_gnt) begin
            r_rd_is_ram <= w_ram_sel;
            r_rd_reg    <= w_led_sel ? r_led : '0;
        end
    end

    assign o_rdata   = r_rd_is_ram ? i_mem_q : r_rd_reg;
    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_led     = r_led;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; lock scenario runs when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, mem_addr, mem_data, led;
    logic        mem_wren;
    logic [15:0] mem_q;
    logic [15:0] ram [256];
`ifdef MEM_ARB_LOCK_EN
    logic        lock0, lock1;
    int          gnt0_cnt;
    bit          got1;
`endif

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_req0     (req0),
        .i_req1     (req1),
        .i_we0      (we0),
        .i_we1      (we1),
        .i_addr0    (addr0),
        .i_addr1    (addr1),
        .i_wdata0   (wdata0),
        .i_wdata1   (wdata1),
`ifdef MEM_ARB_LOCK_EN
        .i_lock0    (lock0),
        .i_lock1    (lock1),
`endif
        .o_gnt0     (gnt0),
        .o_gnt1     (gnt1),
        .o_rvalid0  (rvalid0),
        .o_rvalid1  (rvalid1),
        .o_rdata    (rdata),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .o_mem_wren (mem_wren),
        .i_mem_q    (mem_q),
        .o_led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM on the same (falling) edge: q valid one cycle after the address.
    always @(negedge clk) begin
        if (mem_wren) ram[mem_addr[7:0]] <= mem_data;
        mem_q <= ram[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(posedge clk);
    endtask

    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0;
`ifdef MEM_ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif
    endtask

    task automatic drv0(input logic w, input logic [15:0] a, input logic [15:0] d);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drv1(input logic w, input logic [15:0] a, input logic [15:0] d);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        mem_q = 16'h0;
        idle();
        reset = 1'b1;
        edge_step();
        edge_step();
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_led", 32'(led), 32'h0);
        mid();
        chk("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'h0);
        chk("idle_wren", 32'(mem_wren), 32'd0);
        edge_step();
        reset = 1'b0;

        // RAM write then read-back by requester 0
        drv0(1'b1, 16'h0005, 16'h1234);
        mid();
        chk("wr_gnt0", 32'(gnt0), 32'd1);
        chk("wr_gnt1", 32'(gnt1), 32'd0);
        chk("wr_wren", 32'(mem_wren), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0005);
        chk("wr_mem_data", 32'(mem_data), 32'h1234);
        edge_step();
        chk("wr_no_rvalid", 32'(rvalid0), 32'd0);
        drv0(1'b0, 16'h0005, 16'h0000);
        mid();
        chk("rd_gnt0", 32'(gnt0), 32'd1);
        chk("rd_wren", 32'(mem_wren), 32'd0);
        edge_step();
        idle();
        chk("rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("rd_rvalid1", 32'(rvalid1), 32'd0);
        chk("rd_rdata", 32'(rdata), 32'h1234);
        edge_step();
        chk("rd_rvalid_drop", 32'(rvalid0), 32'd0);

        // Contention right after reset: 0,1,0,1
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        drv0(1'b0, 16'h2000, 16'h0);
        drv1(1'b0, 16'h2000, 16'h0);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("rr_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            chk("rr_gnt1", 32'(gnt1), 32'(i % 2 == 1));
            edge_step();
        end
        idle();
        chk("rr_last_rvalid1", 32'(rvalid1), 32'd1);
        chk("rr_last_rvalid0", 32'(rvalid0), 32'd0);
        chk("rr_last_rdata", 32'(rdata), 32'h0);

        // LED write and read-back by requester 1
        drv1(1'b1, 16'h1000, 16'h00A5);
        mid();
        chk("led_wr_gnt1", 32'(gnt1), 32'd1);
        chk("led_wr_gnt0", 32'(gnt0), 32'd0);
        chk("led_wr_wren", 32'(mem_wren), 32'd0);
        chk("led_wr_addr", 32'(mem_addr), 32'h1000);
        edge_step();
        chk("led_val", 32'(led), 32'h00A5);
        chk("led_wr_no_rvalid", 32'(rvalid1), 32'd0);
        drv1(1'b0, 16'h1000, 16'h0);
        mid();
        chk("led_rd_gnt1", 32'(gnt1), 32'd1);
        edge_step();
        idle();
        chk("led_rd_rvalid1", 32'(rvalid1), 32'd1);
        chk("led_rd_rdata", 32'(rdata), 32'h00A5);

        // Unmapped read returns 0, unmapped write is dropped
        drv0(1'b0, 16'h2000, 16'h0);
        mid();
        chk("unm_rd_gnt0", 32'(gnt0), 32'd1);
        edge_step();
        idle();
        chk("unm_rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("unm_rd_rdata", 32'(rdata), 32'h0);
        drv0(1'b1, 16'h3005, 16'hFFFF);
        mid();
        chk("unm_wr_gnt0", 32'(gnt0), 32'd1);
        chk("unm_wr_wren", 32'(mem_wren), 32'd0);
        edge_step();
        chk("unm_wr_led", 32'(led), 32'h00A5);
        chk("unm_wr_no_rvalid", 32'(rvalid0), 32'd0);
        drv0(1'b0, 16'h0005, 16'h0);
        edge_step();
        idle();
        chk("unm_wr_ram_kept", 32'(rdata), 32'h1234);

        // Reset during grants: gnt stays live, no write, no rvalid, led cleared, requester 0 next
        reset = 1'b1;
        drv0(1'b1, 16'h0007, 16'hBEEF);
        mid();
        chk("rst_wr_gnt0", 32'(gnt0), 32'd1);
        chk("rst_wr_wren", 32'(mem_wren), 32'd0);
        edge_step();
        drv0(1'b0, 16'h1000, 16'h0);
        mid();
        chk("rst_rd_gnt0", 32'(gnt0), 32'd1);
        edge_step();
        reset = 1'b0;
        chk("rst_rd_no_rvalid", 32'(rvalid0), 32'd0);
        chk("rst_rd_led", 32'(led), 32'h0);
        drv0(1'b0, 16'h2000, 16'h0);
        drv1(1'b0, 16'h2000, 16'h0);
        mid();
        chk("post_rst_gnt0", 32'(gnt0), 32'd1);
        chk("post_rst_gnt1", 32'(gnt1), 32'd0);
        edge_step();
        idle();
        drv0(1'b0, 16'h0007, 16'h0);
        edge_step();
        idle();
        chk("rst_wr_ram_kept", 32'(rdata), 32'h0);

`ifdef MEM_ARB_LOCK_EN
        // Lock held by requester 0 for three accesses while requester 1 waits
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        drv0(1'b0, 16'h2000, 16'h0);
        drv1(1'b0, 16'h2000, 16'h0);
        lock0 = 1'b1;
        gnt0_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("lock_gnt0", 32'(gnt0), 32'd1);
            chk("lock_gnt1", 32'(gnt1), 32'd0);
            if (gnt0) gnt0_cnt++;
            edge_step();
        end
        req0 = 1'b0;
        lock0 = 1'b0;
        got1 = 1'b0;
        for (int i = 0; i < 4 && !got1; i++) begin
            mid();
            if (gnt1) got1 = 1'b1;
            chk("lock_release_gnt0", 32'(gnt0), 32'd0);
            edge_step();
        end
        idle();
        chk("lock_gnt0_count", 32'(gnt0_cnt), 32'd3);
        chk("lock_gnt1_after", 32'(got1), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
